// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface pc_fetch_if;
    logic        IReqValid;
    logic        IReqReady;
    logic [31:0] IAddr;
    logic        IRespValid;
    logic [31:0] IRespData;

    modport master (
        output IReqValid, IAddr,
        input  IReqReady, IRespValid, IRespData
    );

    modport slave (
        input  IReqValid, IAddr,
        output IReqReady, IRespValid, IRespData
    );
endinterface

// File: rtl/pc_fetch.sv
// Fetch stage: one-outstanding instruction request, redirect squashing,
// and a 2-entry in-order {pc, instr} buffer feeding decode.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] NPC,
    input  logic        Redirect,
    output logic [31:0] PC,
    pc_fetch_if.master  imem,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    input  logic        DecReady
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  count;
    logic [31:0] pc_q;
    logic [31:0] tag;
    logic [31:0] buf_pc    [2];
    logic [31:0] buf_instr [2];

    logic accept;
    logic push;
    logic pop;

    // Requests are only issued with a free buffer slot, so a push never overflows.
    assign imem.IReqValid = !rst && (state == IDLE) && (count != 2'd2);
    assign imem.IAddr     = pc_q;
    assign PC             = pc_q;

    assign InstrValid = !rst && (count != 2'd0);
    assign Instr      = buf_instr[0];
    assign InstrPC    = buf_pc[0];

    assign accept = imem.IReqValid && imem.IReqReady;
    assign push   = (state == WAIT) && imem.IRespValid && !Redirect;
    assign pop    = InstrValid && DecReady && !Redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= Redirect ? DROP : WAIT;
                        tag   <= pc_q;
                    end
                end
                WAIT: begin
                    if (imem.IRespValid) state <= IDLE;
                    else if (Redirect)   state <= DROP;
                end
                DROP: begin
                    if (imem.IRespValid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (Redirect)    pc_q <= {NPC[31:2], 2'b00};
            else if (accept) pc_q <= pc_q + 32'd4;

            if (Redirect) count <= '0;
            else          count <= count + {1'b0, push} - {1'b0, pop};

            // Pop shifts the tail forward; a same-cycle push lands behind the
            // surviving entry, so the later write to slot 0 wins when count was 1.
            if (pop) begin
                buf_pc[0]    <= buf_pc[1];
                buf_instr[0] <= buf_instr[1];
            end
            if (push) begin
                if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
                    buf_pc[0]    <= tag;
                    buf_instr[0] <= imem.IRespData;
                end else begin
                    buf_pc[1]    <= tag;
                    buf_instr[1] <= imem.IRespData;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_pc_fetch;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] NPC;
    logic        Redirect;
    logic [31:0] PC;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        DecReady;

    pc_fetch_if bus ();

    pc_fetch #(.RESET_PC(RPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .NPC       (NPC),
        .Redirect  (Redirect),
        .PC        (PC),
        .imem      (bus),
        .InstrValid(InstrValid),
        .Instr     (Instr),
        .InstrPC   (InstrPC),
        .DecReady  (DecReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetch address, one outstanding request (kept or squashed),
    // and a queue of {pc, instr} awaiting decode.
    bit          m_known = 1'b0;
    logic [31:0] m_pc;
    logic [31:0] m_tag;
    bit          m_busy = 1'b0;
    bit          m_keep = 1'b0;
    logic [63:0] q[$];

    task automatic model_check();
        bit exp_ivalid;
        chk("IReqValid", {31'd0, bus.IReqValid}, {31'd0, !rst && !m_busy && q.size() < 2});
        exp_ivalid = !rst && q.size() != 0;
        chk("InstrValid", {31'd0, InstrValid}, {31'd0, exp_ivalid});
        if (m_known) begin
            chk("PC", PC, m_pc);
            chk("IAddr", bus.IAddr, m_pc);
        end
        if (exp_ivalid) begin
            chk("Instr", Instr, q[0][31:0]);
            chk("InstrPC", InstrPC, q[0][63:32]);
        end
    endtask

    task automatic model_step();
        bit acc;
        bit popf;
        if (rst) begin
            m_known = 1'b1;
            m_pc    = RPC;
            m_busy  = 1'b0;
            q.delete();
            return;
        end
        acc  = !m_busy && q.size() < 2 && bus.IReqReady;
        popf = q.size() != 0 && DecReady && !Redirect;
        if (m_busy && m_keep && bus.IRespValid && !Redirect)
            q.push_back({m_tag, bus.IRespData});
        if (popf) void'(q.pop_front());
        if (!m_busy) begin
            if (acc) begin
                m_busy = 1'b1;
                m_keep = !Redirect;
                m_tag  = m_pc;
            end
        end else if (bus.IRespValid) begin
            m_busy = 1'b0;
        end else if (Redirect) begin
            m_keep = 1'b0;
        end
        if (Redirect)  m_pc = {NPC[31:2], 2'b00};
        else if (acc)  m_pc = m_pc + 32'd4;
        if (Redirect)  q.delete();
    endtask

    task automatic tick();
        #1;
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit rdy, input bit rv, input logic [31:0] d,
                         input bit rd, input logic [31:0] n, input bit dec);
        rst            = r;
        bus.IReqReady  = rdy;
        bus.IRespValid = rv;
        bus.IRespData  = d;
        Redirect       = rd;
        NPC            = n;
        DecReady       = dec;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
    endtask

    typedef struct {
        logic        r, rdy, rv;
        logic [31:0] d;
        logic        rd;
        logic [31:0] n;
        logic        dec;
        logic        e_ireq;
        logic [31:0] e_iaddr;
        logic        e_ivalid;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        chk_addr;
    } vec_t;

    vec_t vt[9];

    initial begin
        // Sequential fetch: 1-cycle memory, decode always ready.
        vt[0] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         32'h0, 1'b1};
        vt[2] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0,         32'h0, 1'b1};
        vt[3] = '{1'b0, 1'b1, 1'b1, 32'hA000_0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 1'b0, 32'h0,         32'h0, 1'b1};
        vt[4] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b1, 32'hA000_0000, 32'h0, 1'b1};
        vt[5] = '{1'b0, 1'b1, 1'b1, 32'hA111_1111, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 1'b0, 32'h0,         32'h0, 1'b1};
        vt[6] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b1, 32'hA111_1111, 32'h4, 1'b1};
        vt[7] = '{1'b0, 1'b1, 1'b1, 32'hA222_2222, 1'b0, 32'h0, 1'b1, 1'b0, 32'hC, 1'b0, 32'h0,         32'h0, 1'b1};
        vt[8] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b1, 32'hA222_2222, 32'h8, 1'b1};

        for (int i = 0; i < 9; i++) begin
            drive(vt[i].r, vt[i].rdy, vt[i].rv, vt[i].d, vt[i].rd, vt[i].n, vt[i].dec);
            #1;
            chk($sformatf("vec%0d_ireq", i), {31'd0, bus.IReqValid}, {31'd0, vt[i].e_ireq});
            chk($sformatf("vec%0d_ivalid", i), {31'd0, InstrValid}, {31'd0, vt[i].e_ivalid});
            if (vt[i].chk_addr) chk($sformatf("vec%0d_iaddr", i), bus.IAddr, vt[i].e_iaddr);
            if (vt[i].e_ivalid) begin
                chk($sformatf("vec%0d_instr", i), Instr, vt[i].e_instr);
                chk($sformatf("vec%0d_ipc", i), InstrPC, vt[i].e_ipc);
            end
            tick();
        end

        // Backpressure: two pushes fill the buffer, then issue stalls.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, '0,            1'b0, '0, 1'b0); tick();
        drive(1'b0, 1'b1, 1'b1, 32'hB000_0000, 1'b0, '0, 1'b0); tick();
        drive(1'b0, 1'b1, 1'b0, '0,            1'b0, '0, 1'b0); tick();
        drive(1'b0, 1'b1, 1'b1, 32'hB000_0004, 1'b0, '0, 1'b0); tick();
        chk("bp_full_ireq", {31'd0, bus.IReqValid}, 32'd0);
        chk("bp_full_head", InstrPC, 32'h0);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0); tick(); tick();
        chk("bp_stall_ireq", {31'd0, bus.IReqValid}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1); tick();
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("bp_pop_ireq", {31'd0, bus.IReqValid}, 32'd1);
        chk("bp_pop_iaddr", bus.IAddr, 32'h8);
        chk("bp_pop_head", InstrPC, 32'h4);
        tick();

        // Redirect while a request to 0x10 is outstanding.
        do_reset();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h10, 1'b0); tick();
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0); tick();
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h200, 1'b0); tick();
        chk("rw_pc", PC, 32'h200);
        chk("rw_ireq", {31'd0, bus.IReqValid}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 32'hDEAD_0010, 1'b0, '0, 1'b0); tick();
        chk("rw_drop_ivalid", {31'd0, InstrValid}, 32'd0);
        chk("rw_next_iaddr", bus.IAddr, 32'h200);
        chk("rw_next_ireq", {31'd0, bus.IReqValid}, 32'd1);

        // Redirect on the accept cycle, then on a response cycle.
        do_reset();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h40, 1'b0); tick();
        drive(1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h103, 1'b0); tick();
        chk("ra_pc", PC, 32'h100);
        chk("ra_ireq", {31'd0, bus.IReqValid}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 32'hDEAD_0040, 1'b0, '0, 1'b0); tick();
        chk("ra_drop_ivalid", {31'd0, InstrValid}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0); tick();
        drive(1'b0, 1'b0, 1'b1, 32'hDEAD_0100, 1'b1, 32'h300, 1'b0); tick();
        chk("rr_ivalid", {31'd0, InstrValid}, 32'd0);
        chk("rr_iaddr", bus.IAddr, 32'h300);
        chk("rr_ireq", {31'd0, bus.IReqValid}, 32'd1);

        // Reset while waiting on a response with a buffered entry.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, '0,            1'b0, '0, 1'b0); tick();
        drive(1'b0, 1'b1, 1'b1, 32'hC000_0000, 1'b0, '0, 1'b0); tick();
        drive(1'b0, 1'b1, 1'b0, '0,            1'b0, '0, 1'b0); tick();
        drive(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        #1;
        chk("mr_rst_ireq", {31'd0, bus.IReqValid}, 32'd0);
        chk("mr_rst_ivalid", {31'd0, InstrValid}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 32'hC000_0004, 1'b0, '0, 1'b0); tick();
        chk("mr_late_ivalid", {31'd0, InstrValid}, 32'd0);
        chk("mr_pc", PC, RPC);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("mr_first_ireq", {31'd0, bus.IReqValid}, 32'd1);
        chk("mr_first_iaddr", bus.IAddr, RPC);
        tick();

        // PC wrap at the top of the address space.
        do_reset();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1, 32'hFFFF_FFFF, 1'b0); tick();
        chk("wr_pc", PC, 32'hFFFF_FFFC);
        drive(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0); tick();
        chk("wr_next_iaddr", bus.IAddr, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'hE000_000F, 1'b0, '0, 1'b0); tick();
        chk("wr_ipc", InstrPC, 32'hFFFF_FFFC);
        chk("wr_instr", Instr, 32'hE000_000F);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70,
                  $urandom_range(0, 1) == 1, $urandom(),
                  $urandom_range(0, 99) < 8, $urandom(),
                  $urandom_range(0, 99) < 60);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
